// File: rtl/ecc_mont_result_collector.sv
// Word-serial result collector for the Montgomery multiplier: gathers LSW-first words,
// subtracts p once, presents the reduced result. Optional macro: ECC_RESULT_MASK_EN.
module ecc_mont_result_collector #(
  parameter  int RADIX     = 32,
  parameter  int NUM_WORDS = 12,
  localparam int REG_SIZE  = RADIX*NUM_WORDS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                zeroize,
  input  logic                start_i,
  input  logic                word_valid_i,
  input  logic [RADIX-1:0]    word_i,
  input  logic                carry_i,
  input  logic [REG_SIZE-1:0] p_i,
  output logic [REG_SIZE-1:0] result_o,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic                busy_o,
  output logic                word_drop_o
);
  localparam int CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_WORDS-1);

  typedef enum logic [1:0] {IDLE, COLLECT, SUB, DONE} state_t;

  state_t                          state;
  logic [CW-1:0]                   cnt;
  logic [NUM_WORDS-1:0][RADIX-1:0] t_buf, d_buf, p_w;
  logic                            top_carry, borrow, sel_d;
  logic [RADIX:0]                  diff;
  logic [REG_SIZE-1:0]             sel_val;

  assign p_w     = p_i;
  assign diff    = {1'b0, t_buf[cnt]} - {1'b0, p_w[cnt]} - {{RADIX{1'b0}}, borrow};
  assign sel_val = sel_d ? d_buf : t_buf;

`ifdef ECC_RESULT_MASK_EN
  assign result_o = result_valid_o ? sel_val : '0;
`else
  assign result_o = sel_val;
`endif

  always_ff @(posedge clk) begin
    if (reset || zeroize) begin
      state          <= IDLE;
      cnt            <= '0;
      t_buf          <= '0;
      d_buf          <= '0;
      top_carry      <= 1'b0;
      borrow         <= 1'b0;
      sel_d          <= 1'b0;
      result_valid_o <= 1'b0;
      busy_o         <= 1'b0;
      word_drop_o    <= 1'b0;
    end else if (start_i) begin
      // start aborts anything in flight; a coincident word is silently discarded
      state          <= COLLECT;
      cnt            <= '0;
      top_carry      <= 1'b0;
      borrow         <= 1'b0;
      result_valid_o <= 1'b0;
      busy_o         <= 1'b1;
      word_drop_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (word_valid_i) word_drop_o <= 1'b1;
        COLLECT: if (word_valid_i) begin
          t_buf[cnt] <= word_i;
          if (cnt == LAST) begin
            top_carry <= carry_i;
            cnt       <= '0;
            state     <= SUB;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SUB: begin
          if (word_valid_i) word_drop_o <= 1'b1;
          d_buf[cnt] <= diff[RADIX-1:0];
          borrow     <= diff[RADIX];
          if (cnt == LAST) begin
            // final borrow is only known now, so the choice is latched as we leave SUB
            sel_d          <= top_carry | ~diff[RADIX];
            cnt            <= '0;
            state          <= DONE;
            result_valid_o <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (word_valid_i) word_drop_o <= 1'b1;
          if (result_ready_i) begin
            state          <= IDLE;
            result_valid_o <= 1'b0;
            busy_o         <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ecc_mont_result_collector.sv
// Directed bench for ecc_mont_result_collector with NUM_WORDS=2, RADIX=32.
module tb_ecc_mont_result_collector;
  localparam int RADIX = 32;
  localparam int NW    = 2;
  localparam int RS    = RADIX*NW;

  logic          clk = 1'b0;
  logic          reset, zeroize, start_i, word_valid_i, carry_i, result_ready_i;
  logic [31:0]   word_i;
  logic [RS-1:0] p_i, result_o;
  logic          result_valid_o, busy_o, word_drop_o;

  int tests = 0;
  int fails = 0;

  ecc_mont_result_collector #(.RADIX(RADIX), .NUM_WORDS(NW)) dut (
    .clk(clk), .reset(reset), .zeroize(zeroize), .start_i(start_i),
    .word_valid_i(word_valid_i), .word_i(word_i), .carry_i(carry_i), .p_i(p_i),
    .result_o(result_o), .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .busy_o(busy_o), .word_drop_o(word_drop_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    logic        c;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_result"}, result_o, 64'h0);
    check({tag, "_valid"}, {63'h0, result_valid_o}, 64'h0);
    check({tag, "_busy"}, {63'h0, busy_o}, 64'h0);
    check({tag, "_drop"}, {63'h0, word_drop_o}, 64'h0);
  endtask

  // start, then two back-to-back words; returns just after the last-word edge
  task automatic send_op(input logic [31:0] w0, input logic [31:0] w1, input logic c);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    word_valid_i = 1'b1; word_i = w0; carry_i = 1'b0;
    tick();
    word_i = w1; carry_i = c;
    tick();
    word_valid_i = 1'b0; carry_i = 1'b0; word_i = '0;
  endtask

  initial begin
    vecs[0] = '{32'h0000_0007, 32'h0000_0000, 1'b0, 64'h0000_0000_0000_0007, "small"};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_000F, 1'b0, 64'h0000_0000_0000_0002, "above_p"};
    vecs[2] = '{32'hFFFF_FFFD, 32'h0000_000F, 1'b0, 64'h0000_0000_0000_0000, "equal_p"};
    vecs[3] = '{32'h0000_0001, 32'h0000_0000, 1'b1, 64'hFFFF_FFF0_0000_0004, "carry"};

    reset = 1'b1; zeroize = 1'b0; start_i = 1'b0; word_valid_i = 1'b0;
    word_i = '0; carry_i = 1'b0; result_ready_i = 1'b0;
    p_i = 64'h0000_000F_FFFF_FFFD;
    tick(); tick();
    reset = 1'b0;
    check_reset_state("reset");

    foreach (vecs[i]) begin
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check({vecs[i].name, "_busy_rise"}, {63'h0, busy_o}, 64'h1);
      word_valid_i = 1'b1; word_i = vecs[i].w0;
      tick();
      word_i = vecs[i].w1; carry_i = vecs[i].c;
      tick();
      word_valid_i = 1'b0; carry_i = 1'b0;
      tick();
      check({vecs[i].name, "_valid_early"}, {63'h0, result_valid_o}, 64'h0);
      tick();
      check({vecs[i].name, "_valid_lat"}, {63'h0, result_valid_o}, 64'h1);
      check({vecs[i].name, "_result"}, result_o, vecs[i].exp);
      result_ready_i = 1'b1;
      tick();
      result_ready_i = 1'b0;
      check({vecs[i].name, "_valid_fall"}, {63'h0, result_valid_o}, 64'h0);
      check({vecs[i].name, "_busy_fall"}, {63'h0, busy_o}, 64'h0);
`ifdef ECC_RESULT_MASK_EN
      check({vecs[i].name, "_masked"}, result_o, 64'h0);
`else
      check({vecs[i].name, "_held"}, result_o, vecs[i].exp);
`endif
    end

    // restart after the first word; the word coincident with start is dropped silently
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    word_valid_i = 1'b1; word_i = 32'h7;
    tick();
    start_i = 1'b1; word_i = 32'h99;
    tick();
    start_i = 1'b0; word_i = 32'h5;
    tick();
    word_i = 32'h0;
    tick();
    word_valid_i = 1'b0;
    tick(); tick();
    check("restart_valid", {63'h0, result_valid_o}, 64'h1);
    check("restart_result", result_o, 64'h5);
    check("restart_nodrop", {63'h0, word_drop_o}, 64'h0);

    // back-pressure with a stray word in DONE
    word_valid_i = 1'b1; word_i = 32'hDEAD_BEEF;
    tick();
    word_valid_i = 1'b0;
    tick(); tick(); tick(); tick();
    check("bp_result", result_o, 64'h5);
    check("bp_valid", {63'h0, result_valid_o}, 64'h1);
    check("bp_drop", {63'h0, word_drop_o}, 64'h1);
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
    check("bp_valid_fall", {63'h0, result_valid_o}, 64'h0);
    check("bp_idle", {63'h0, busy_o}, 64'h0);
    check("bp_drop_sticky", {63'h0, word_drop_o}, 64'h1);

    // reset in the middle of SUB
    send_op(32'h7, 32'h0, 1'b0);
    tick();
    check("sub_busy", {63'h0, busy_o}, 64'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("reset_sub");
    tick(); tick();
    check("reset_sub_stays", {63'h0, result_valid_o}, 64'h0);

    // zeroize in the middle of COLLECT
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    word_valid_i = 1'b1; word_i = 32'h1234;
    tick();
    word_valid_i = 1'b0;
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    check_reset_state("zeroize_col");

    // stray word in IDLE sets the flag, next start clears it
    word_valid_i = 1'b1;
    tick();
    word_valid_i = 1'b0;
    check("idle_drop", {63'h0, word_drop_o}, 64'h1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("start_clears_drop", {63'h0, word_drop_o}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
